// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared types and constants for the UART command parser: the parser FSM
//   state encoding, the frame sync byte, the supported opcodes and the error
//   codes reported on oErrCode.
//   Optional feature macro used by the parser: CMD_CHECKSUM_EN.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPC   = 3'd1,
        S_OPA   = 3'd2,
        S_OPB   = 3'd3,
        S_CHK   = 3'd4,
        S_ISSUE = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [7:0] OP_DIV = 8'h04;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OPCODE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    // Opcodes form a contiguous range, so a range test covers all of them.
    function automatic logic isValidOpcode(input logic [7:0] op);
        return (op >= OP_ADD) && (op <= OP_DIV);
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer
//   Inter-byte gap watchdog. Counts enabled cycles since the last clear and
//   raises expired for one cycle once CYCLES enabled cycles have elapsed.
//   A clear in the same cycle suppresses expiry, so a byte arriving exactly
//   at the deadline always wins.
// Ports:
//   iClk, iRst  clock, asynchronous active-low reset
//   clear       restart the gap measurement (driven by each received byte)
//   enable      count only while a frame is in progress
//   expired     gap limit reached
module uart_gap_timer #(
    parameter int unsigned CYCLES = 200
) (
    input  logic iClk,
    input  logic iRst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count;

    assign expired = enable && !clear && (count == W'(CYCLES - 1));

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            count <= '0;
        end else if (clear || !enable || expired) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Assembles command frames from a byte stream delivered by uart_rx:
//     A5, OPCODE, A[31:24..7:0], B[31:24..7:0] [, CHK]
//   and presents {opcode, A, B} to the arithmetic unit with a valid/ready
//   handshake. Bad opcodes, inter-byte timeouts and (optionally) checksum
//   mismatches produce a one-cycle oFrameErr pulse with the cause on
//   oErrCode, which holds until the next error.
//   Handshake: oOpValid stays high with oOpcode/oOpA/oOpB stable until the
//   cycle in which iOpReady is also high; that cycle is the transfer.
//   Optional feature macro: CMD_CHECKSUM_EN adds a trailing XOR checksum
//   byte covering OPCODE and all eight operand bytes.
// Ports:
//   iClk, iRst       clock, asynchronous active-low reset
//   iRxByte/iRxDone  received byte and its one-cycle strobe
//   oOpValid/iOpReady command handshake
//   oOpcode, oOpA, oOpB  decoded command
//   oFrameErr, oErrCode  error pulse and cause
//   oState           current FSM state (debug visibility)
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [7:0]  iRxByte,
    input  logic        iRxDone,
    output logic        oOpValid,
    input  logic        iOpReady,
    output logic [7:0]  oOpcode,
    output logic [31:0] oOpA,
    output logic [31:0] oOpB,
    output logic        oFrameErr,
    output logic [1:0]  oErrCode,
    output state_t      oState
);

    // 64-bit intermediate: TIMEOUT_BITS*CLK_FREQ overflows 32 bits easily.
    localparam longint unsigned TIMEOUT_WIDE =
        (64'(TIMEOUT_BITS) * 64'(CLK_FREQ)) / 64'(BAUD_RATE);
    localparam int unsigned TIMEOUT_CYCLES = 32'(TIMEOUT_WIDE);

    state_t     state;
    state_t     stateNext;
    logic [1:0] byteIdx;
    logic       gapEnable;
    logic       gapExpired;
    logic       errPulse;
    logic [1:0] errCodeNext;
    logic       loadOpc;
    logic       shiftA;
    logic       shiftB;
`ifdef CMD_CHECKSUM_EN
    logic [7:0] chkAcc;
`endif

    assign gapEnable = (state == S_OPC) || (state == S_OPA) ||
                       (state == S_OPB) || (state == S_CHK);
    assign oOpValid  = (state == S_ISSUE);
    assign oState    = state;

    uart_gap_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) gapTimer (
        .iClk    (iClk),
        .iRst    (iRst),
        .clear   (iRxDone),
        .enable  (gapEnable),
        .expired (gapExpired)
    );

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        errPulse    = 1'b0;
        errCodeNext = oErrCode;
        loadOpc     = 1'b0;
        shiftA      = 1'b0;
        shiftB      = 1'b0;
        case (state)
            S_IDLE: begin
                if (iRxDone && (iRxByte == SYNC_BYTE)) stateNext = S_OPC;
            end
            S_OPC: begin
                if (iRxDone) begin
                    if (isValidOpcode(iRxByte)) begin
                        loadOpc   = 1'b1;
                        stateNext = S_OPA;
                    end else begin
                        errPulse    = 1'b1;
                        errCodeNext = ERR_OPCODE;
                        stateNext   = S_IDLE;
                    end
                end
            end
            S_OPA: begin
                if (iRxDone) begin
                    shiftA = 1'b1;
                    if (byteIdx == 2'd3) stateNext = S_OPB;
                end
            end
            S_OPB: begin
                if (iRxDone) begin
                    shiftB = 1'b1;
`ifdef CMD_CHECKSUM_EN
                    if (byteIdx == 2'd3) stateNext = S_CHK;
`else
                    if (byteIdx == 2'd3) stateNext = S_ISSUE;
`endif
                end
            end
`ifdef CMD_CHECKSUM_EN
            S_CHK: begin
                if (iRxDone) begin
                    if (iRxByte == chkAcc) begin
                        stateNext = S_ISSUE;
                    end else begin
                        errPulse    = 1'b1;
                        errCodeNext = ERR_CHECKSUM;
                        stateNext   = S_IDLE;
                    end
                end
            end
`endif
            // Bytes arriving while a command waits are dropped silently.
            S_ISSUE: begin
                if (iOpReady) stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase

        // Timer only expires in byte-consuming states and never in a cycle
        // that carries a byte, so the byte always takes precedence.
        if (gapExpired) begin
            errPulse    = 1'b1;
            errCodeNext = ERR_TIMEOUT;
            stateNext   = S_IDLE;
        end
    end

    // Operand registers double as the outputs; partial frames may leave
    // stale bytes in them, which is harmless because only oOpValid
    // qualifies their use.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            byteIdx   <= 2'd0;
            oOpcode   <= 8'h00;
            oOpA      <= 32'h0;
            oOpB      <= 32'h0;
            oFrameErr <= 1'b0;
            oErrCode  <= ERR_NONE;
        end else begin
            oFrameErr <= errPulse;
            oErrCode  <= errCodeNext;
            if (stateNext == S_IDLE) begin
                byteIdx <= 2'd0;
            end else if (shiftA || shiftB) begin
                byteIdx <= byteIdx + 2'd1;
            end
            if (loadOpc) oOpcode <= iRxByte;
            if (shiftA)  oOpA    <= {oOpA[23:0], iRxByte};
            if (shiftB)  oOpB    <= {oOpB[23:0], iRxByte};
        end
    end

`ifdef CMD_CHECKSUM_EN
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            chkAcc <= 8'h00;
        end else if (loadOpc) begin
            chkAcc <= iRxByte;
        end else if (shiftA || shiftB) begin
            chkAcc <= chkAcc ^ iRxByte;
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Directed bench for uart_cmd_parser with a 200-cycle gap timeout
//   (CLK_FREQ=100, BAUD_RATE=10, TIMEOUT_BITS=20). Checksum scenarios are
//   included when CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_done = 1'b0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [7:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        frame_err;
    logic [1:0]  err_code;
    state_t      dbg_state;

    int vec_count = 0;
    int miscompares = 0;
    int err_seen = 0;

    uart_cmd_parser #(
        .CLK_FREQ     (100),
        .BAUD_RATE    (10),
        .TIMEOUT_BITS (20)
    ) dut (
        .iClk      (clk),
        .iRst      (rst_n),
        .iRxByte   (rx_byte),
        .iRxDone   (rx_done),
        .oOpValid  (op_valid),
        .iOpReady  (op_ready),
        .oOpcode   (opcode),
        .oOpA      (op_a),
        .oOpB      (op_b),
        .oFrameErr (frame_err),
        .oErrCode  (err_code),
        .oState    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) if (rst_n && frame_err) err_seen++;

    // ---------------- helpers ----------------
    typedef struct {
        logic [7:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  exp_opc;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] chk_of(input logic [7:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
        return opc ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0]
                   ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0];
    endfunction

    // Sends a full frame with two idle cycles between bytes and none after
    // the last one, so the caller sees oOpValid on return.
    task automatic send_frame(input logic [7:0] opc, input logic [31:0] a,
                              input logic [31:0] b, input logic [7:0] chk);
        logic [7:0] q[$];
        q.push_back(SYNC_BYTE);
        q.push_back(opc);
        for (int i = 3; i >= 0; i--) q.push_back(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) q.push_back(b[8*i +: 8]);
`ifdef CMD_CHECKSUM_EN
        q.push_back(chk);
`else
        if (chk == 8'h00) q.push_back(8'h00);  // keep arg referenced
        if (chk == 8'h00) void'(q.pop_back());
`endif
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i]);
            if (i != q.size() - 1) idle(2);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int err0;
        int n;
        logic stable;
        logic seen_valid;

        vecs[0] = '{8'h01, 32'h0000_0005, 32'h0000_0003, 8'h01, 32'h0000_0005, 32'h0000_0003};
        vecs[1] = '{8'h02, 32'hDEAD_BEEF, 32'h1234_5678, 8'h02, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[2] = '{8'h03, 32'hFFFF_FFFF, 32'h0000_0000, 8'h03, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3] = '{8'h04, 32'h8000_0001, 32'h7FFF_FFFE, 8'h04, 32'h8000_0001, 32'h7FFF_FFFE};

        // Reset state
        idle(3);
        check("rst_valid", 32'(op_valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_code", 32'(err_code), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_a", op_a, 0);
        check("rst_b", op_b, 0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1'b1;
        idle(2);

        // Table-driven good frames, ready held high
        op_ready = 1'b1;
        err0 = err_seen;
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].opc, vecs[v].a, vecs[v].b, chk_of(vecs[v].opc, vecs[v].a, vecs[v].b));
            check("vec_valid", 32'(op_valid), 1);
            check("vec_opcode", 32'(opcode), 32'(vecs[v].exp_opc));
            check("vec_a", op_a, vecs[v].exp_a);
            check("vec_b", op_b, vecs[v].exp_b);
            idle(1);
            check("vec_valid_one_cycle", 32'(op_valid), 0);
            idle(3);
        end
        check("vec_no_err", 32'(err_seen - err0), 0);

        // Backpressure with stray bytes while the command waits
        op_ready = 1'b0;
        err0 = err_seen;
        send_frame(8'h01, 32'd5, 32'd3, 8'h07);
        check("bp_valid", 32'(op_valid), 1);
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!(op_valid === 1'b1 && opcode === 8'h01 && op_a === 32'd5 && op_b === 32'd3))
                stable = 1'b0;
            if (c == 10 || c == 20) begin
                rx_byte = (c == 10) ? 8'h11 : 8'h22;
                rx_done = 1'b1;
            end else begin
                rx_done = 1'b0;
            end
        end
        check("bp_stable", 32'(stable), 1);
        op_ready = 1'b1;
        idle(1);
        check("bp_done_valid", 32'(op_valid), 0);
        check("bp_done_state", 32'(dbg_state), 32'(S_IDLE));
        check("bp_a_kept", op_a, 32'd5);
        check("bp_no_err", 32'(err_seen - err0), 0);
        idle(3);

        // Bad opcode then resync on a good frame
        send_byte(8'h33); idle(2);
        send_byte(8'hA5); idle(2);
        send_byte(8'h09);
        check("badop_err", 32'(frame_err), 1);
        check("badop_code", 32'(err_code), 1);
        check("badop_state", 32'(dbg_state), 32'(S_IDLE));
        idle(1);
        check("badop_pulse_end", 32'(frame_err), 0);
        check("badop_code_hold", 32'(err_code), 1);
        send_frame(8'h02, 32'h0000_0100, 32'h0000_00FF, chk_of(8'h02, 32'h100, 32'hFF));
        check("resync_valid", 32'(op_valid), 1);
        check("resync_opcode", 32'(opcode), 32'h02);
        check("resync_a", op_a, 32'h100);
        check("resync_b", op_b, 32'hFF);
        idle(3);

        // Gap timeout mid-operand
        send_byte(8'hA5); idle(2);
        send_byte(8'h03); idle(2);
        send_byte(8'h12); idle(2);
        send_byte(8'h34);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (frame_err) break;
        end
        check("timeout_cycles", n, 200);
        check("timeout_code", 32'(err_code), 2);
        check("timeout_state", 32'(dbg_state), 32'(S_IDLE));
        check("timeout_valid", 32'(op_valid), 0);
        idle(3);

`ifdef CMD_CHECKSUM_EN
        // Checksum mismatch, then correct checksum
        send_frame(8'h04, 32'h10, 32'h2, 8'h00);
        check("chk_bad_err", 32'(frame_err), 1);
        check("chk_bad_code", 32'(err_code), 3);
        check("chk_bad_valid", 32'(op_valid), 0);
        idle(3);
        send_frame(8'h04, 32'h10, 32'h2, 8'h16);
        check("chk_good_valid", 32'(op_valid), 1);
        check("chk_good_opcode", 32'(opcode), 32'h04);
        check("chk_good_a", op_a, 32'h10);
        check("chk_good_b", op_b, 32'h2);
        idle(3);
`endif

        // Reset after the A bytes, then the rest of the frame
        send_byte(8'hA5); idle(2);
        send_byte(8'h01); idle(2);
        for (int i = 0; i < 4; i++) begin
            send_byte((i == 3) ? 8'h05 : 8'h00);
            idle(2);
        end
        rst_n = 1'b0;
        idle(1);
        check("midrst_a", op_a, 0);
        check("midrst_opcode", 32'(opcode), 0);
        check("midrst_code", 32'(err_code), 0);
        check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1'b1;
        idle(2);
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte((i == 3) ? 8'h03 : 8'h00);
            if (op_valid) seen_valid = 1'b1;
            idle(2);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (op_valid || frame_err) seen_valid = 1'b1;
        end
        check("midrst_no_valid", 32'(seen_valid), 0);
        check("midrst_b", op_b, 0);

        // Reset while a command waits for ready
        op_ready = 1'b0;
        send_frame(8'h03, 32'd7, 32'd9, chk_of(8'h03, 32'd7, 32'd9));
        check("issrst_valid_before", 32'(op_valid), 1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_valid) seen_valid = 1'b1;
        end
        check("issrst_no_valid", 32'(seen_valid), 0);
        check("issrst_a", op_a, 0);

        // Recovery after reset
        op_ready = 1'b1;
        send_frame(8'h04, 32'h0000_0064, 32'h0000_0005, chk_of(8'h04, 32'h64, 32'h5));
        check("recover_valid", 32'(op_valid), 1);
        check("recover_a", op_a, 32'h64);
        check("recover_b", op_b, 32'h5);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
